// File: rtl/iic_arb_pkg.sv
// iic_arb_pkg -- shared definitions for the two-client iic_drive arbiter.
//   arb_state_e : one-hot arbiter FSM state encoding
//   REQ_NUM     : number of clients sharing the master
//   BYTE_NUM_W  : width of the byte-count field of a request
//   WORD_ADDR_W : width of the register-address field of a request
package iic_arb_pkg;

  localparam int REQ_NUM     = 2;
  localparam int BYTE_NUM_W  = 4;
  localparam int WORD_ADDR_W = 8;

  typedef enum logic [4:0] {
    S_IDLE      = 5'b00001,
    S_ISSUE     = 5'b00010,
    S_WAIT_LOW  = 5'b00100,
    S_WAIT_DONE = 5'b01000,
    S_DONE      = 5'b10000
  } arb_state_e;

endpackage

// File: rtl/iic_req_slot.sv
// iic_req_slot -- one client's request holding register plus pending flag.
//   clk, rst       : clock, synchronous active-high reset
//   start_i        : request pulse; fields are captured when ready_o is high
//   rw_flag_i, byte_num_i, word_addr_i, wdata_i : request fields
//   owner_busy_i   : arbiter is busy serving this client
//   clear_i        : arbiter has consumed the pending request
//   ready_o        : client may issue a new request
//   pending_o      : a captured request awaits service
//   rw_flag_o, byte_num_o, word_addr_o, wdata_o : captured fields
module iic_req_slot
  import iic_arb_pkg::*;
#(
  parameter int P_DATA_W = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   rw_flag_i,
  input  logic [BYTE_NUM_W-1:0]  byte_num_i,
  input  logic [WORD_ADDR_W-1:0] word_addr_i,
  input  logic [P_DATA_W-1:0]    wdata_i,
  input  logic                   owner_busy_i,
  input  logic                   clear_i,
  output logic                   ready_o,
  output logic                   pending_o,
  output logic                   rw_flag_o,
  output logic [BYTE_NUM_W-1:0]  byte_num_o,
  output logic [WORD_ADDR_W-1:0] word_addr_o,
  output logic [P_DATA_W-1:0]    wdata_o
);

  logic                   pending_q, pending_d;
  logic                   rw_flag_q, rw_flag_d;
  logic [BYTE_NUM_W-1:0]  byte_num_q, byte_num_d;
  logic [WORD_ADDR_W-1:0] word_addr_q, word_addr_d;
  logic [P_DATA_W-1:0]    wdata_q, wdata_d;
  logic                   accept;

  // A client stays blocked until its transaction has fully completed,
  // including the done cycle, so a start coincident with done is dropped.
  assign ready_o = !pending_q && !owner_busy_i;
  assign accept  = start_i && ready_o;

  always_comb begin
    pending_d   = pending_q;
    rw_flag_d   = rw_flag_q;
    byte_num_d  = byte_num_q;
    word_addr_d = word_addr_q;
    wdata_d     = wdata_q;
    if (clear_i) begin
      pending_d = 1'b0;
    end
    if (accept) begin
      pending_d   = 1'b1;
      rw_flag_d   = rw_flag_i;
      byte_num_d  = byte_num_i;
      word_addr_d = word_addr_i;
      wdata_d     = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= 1'b0;
      rw_flag_q   <= 1'b0;
      byte_num_q  <= '0;
      word_addr_q <= '0;
      wdata_q     <= '0;
    end else begin
      pending_q   <= pending_d;
      rw_flag_q   <= rw_flag_d;
      byte_num_q  <= byte_num_d;
      word_addr_q <= word_addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign pending_o   = pending_q;
  assign rw_flag_o   = rw_flag_q;
  assign byte_num_o  = byte_num_q;
  assign word_addr_o = word_addr_q;
  assign wdata_o     = wdata_q;

endmodule

// File: rtl/iic_bus_arbiter.sv
// iic_bus_arbiter -- shares one iic_drive master between two clients.
// Requests are held per client, granted round-robin, sequenced through the
// master's start/ready handshake and completed back to the owning client.
// A watchdog and a lost-start detector free the bus if the master hangs.
//   clk, rst           : clock, synchronous active-high reset
//   reqN_*  (N = 0,1)  : client request fields in, ready/done/status/read data out
//   m_*                : iic_drive handshake, fields and returned status/data
module iic_bus_arbiter
  import iic_arb_pkg::*;
#(
  parameter int P_TIMEOUT_CYC  = 50_000,
  parameter int P_LOW_WAIT_MAX = 8,
  parameter int P_DATA_W       = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_start,
  input  logic                   req0_rw_flag,
  input  logic [BYTE_NUM_W-1:0]  req0_byte_num,
  input  logic [WORD_ADDR_W-1:0] req0_word_addr,
  input  logic [P_DATA_W-1:0]    req0_wdata,
  output logic                   req0_ready,
  output logic [P_DATA_W-1:0]    req0_rdata,
  output logic                   req0_rdata_valid,
  output logic                   req0_done,
  output logic                   req0_ack_error,
  output logic                   req0_timeout,
  input  logic                   req1_start,
  input  logic                   req1_rw_flag,
  input  logic [BYTE_NUM_W-1:0]  req1_byte_num,
  input  logic [WORD_ADDR_W-1:0] req1_word_addr,
  input  logic [P_DATA_W-1:0]    req1_wdata,
  output logic                   req1_ready,
  output logic [P_DATA_W-1:0]    req1_rdata,
  output logic                   req1_rdata_valid,
  output logic                   req1_done,
  output logic                   req1_ack_error,
  output logic                   req1_timeout,
  output logic                   m_start,
  input  logic                   m_ready,
  output logic                   m_rw_flag,
  output logic [BYTE_NUM_W-1:0]  m_byte_num,
  output logic [WORD_ADDR_W-1:0] m_word_addr,
  output logic [P_DATA_W-1:0]    m_wdata,
  input  logic [P_DATA_W-1:0]    m_rdata,
  input  logic                   m_rdata_valid,
  input  logic                   m_ack_error
);

  localparam int WD_W  = $clog2(P_TIMEOUT_CYC + 1);
  localparam int LOW_W = $clog2(P_LOW_WAIT_MAX + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(P_TIMEOUT_CYC - 1);
  localparam logic [LOW_W-1:0] LOW_LAST = LOW_W'(P_LOW_WAIT_MAX - 1);

  arb_state_e             state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;
  logic                   err_q, err_d;
  logic                   timeout_q, timeout_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [LOW_W-1:0]       low_q, low_d;
  logic                   m_start_q, m_start_d;
  logic                   m_rw_flag_q, m_rw_flag_d;
  logic [BYTE_NUM_W-1:0]  m_byte_num_q, m_byte_num_d;
  logic [WORD_ADDR_W-1:0] m_word_addr_q, m_word_addr_d;
  logic [P_DATA_W-1:0]    m_wdata_q, m_wdata_d;

  logic                   busy;
  logic                   wd_hit;
  logic                   sel;
  logic [REQ_NUM-1:0]     start_v, rw_in_v, ready_v, pending_v, clear_v, owner_v, rw_slot_v;
  logic [BYTE_NUM_W-1:0]  byte_num_in   [REQ_NUM];
  logic [BYTE_NUM_W-1:0]  byte_num_slot [REQ_NUM];
  logic [WORD_ADDR_W-1:0] addr_in       [REQ_NUM];
  logic [WORD_ADDR_W-1:0] addr_slot     [REQ_NUM];
  logic [P_DATA_W-1:0]    wdata_in      [REQ_NUM];
  logic [P_DATA_W-1:0]    wdata_slot    [REQ_NUM];

  assign start_v        = {req1_start, req0_start};
  assign rw_in_v        = {req1_rw_flag, req0_rw_flag};
  assign byte_num_in[0] = req0_byte_num;
  assign byte_num_in[1] = req1_byte_num;
  assign addr_in[0]     = req0_word_addr;
  assign addr_in[1]     = req1_word_addr;
  assign wdata_in[0]    = req0_wdata;
  assign wdata_in[1]    = req1_wdata;

  assign busy   = (state_q != S_IDLE);
  assign wd_hit = (wd_q == WD_LAST);

  generate
    for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_slot
      assign owner_v[gi] = busy && (int'(grant_q) == gi);

      iic_req_slot #(
        .P_DATA_W (P_DATA_W)
      ) u_slot (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_v[gi]),
        .rw_flag_i    (rw_in_v[gi]),
        .byte_num_i   (byte_num_in[gi]),
        .word_addr_i  (addr_in[gi]),
        .wdata_i      (wdata_in[gi]),
        .owner_busy_i (owner_v[gi]),
        .clear_i      (clear_v[gi]),
        .ready_o      (ready_v[gi]),
        .pending_o    (pending_v[gi]),
        .rw_flag_o    (rw_slot_v[gi]),
        .byte_num_o   (byte_num_slot[gi]),
        .word_addr_o  (addr_slot[gi]),
        .wdata_o      (wdata_slot[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    err_d         = err_q;
    timeout_d     = timeout_q;
    wd_d          = wd_q;
    low_d         = low_q;
    m_start_d     = 1'b0;
    m_rw_flag_d   = m_rw_flag_q;
    m_byte_num_d  = m_byte_num_q;
    m_word_addr_d = m_word_addr_q;
    m_wdata_d     = m_wdata_q;
    clear_v       = '0;
    // With both pending, the client not served last wins; otherwise the
    // single pending client is picked.
    sel           = (pending_v == 2'b11) ? ~last_grant_q : pending_v[1];

    unique case (state_q)
      S_IDLE: begin
        if (|pending_v) begin
          grant_d       = sel;
          m_rw_flag_d   = rw_slot_v[sel];
          m_byte_num_d  = byte_num_slot[sel];
          m_word_addr_d = addr_slot[sel];
          m_wdata_d     = wdata_slot[sel];
          wd_d          = '0;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d = wd_q + 1'b1;
        if (wd_hit) begin
          // Master never became ready: the request is dropped, not retried.
          clear_v[grant_q] = 1'b1;
          last_grant_d     = grant_q;
          timeout_d        = 1'b1;
          state_d          = S_DONE;
        end else if (m_ready) begin
          m_start_d        = 1'b1;
          clear_v[grant_q] = 1'b1;
          last_grant_d     = grant_q;
          wd_d             = '0;
          low_d            = '0;
          state_d          = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        wd_d = wd_q + 1'b1;
        if (wd_hit) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else if (!m_ready) begin
          state_d = S_WAIT_DONE;
        end else if (low_q == LOW_LAST) begin
          // Master ignored the start pulse.
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          low_d = low_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        wd_d = wd_q + 1'b1;
        if (m_ack_error) begin
          err_d = 1'b1;
        end
        if (wd_hit) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else if (m_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        err_d     = 1'b0;
        timeout_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      err_q         <= 1'b0;
      timeout_q     <= 1'b0;
      wd_q          <= '0;
      low_q         <= '0;
      m_start_q     <= 1'b0;
      m_rw_flag_q   <= 1'b0;
      m_byte_num_q  <= '0;
      m_word_addr_q <= '0;
      m_wdata_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      err_q         <= err_d;
      timeout_q     <= timeout_d;
      wd_q          <= wd_d;
      low_q         <= low_d;
      m_start_q     <= m_start_d;
      m_rw_flag_q   <= m_rw_flag_d;
      m_byte_num_q  <= m_byte_num_d;
      m_word_addr_q <= m_word_addr_d;
      m_wdata_q     <= m_wdata_d;
    end
  end

  assign m_start     = m_start_q;
  assign m_rw_flag   = m_rw_flag_q;
  assign m_byte_num  = m_byte_num_q;
  assign m_word_addr = m_word_addr_q;
  assign m_wdata     = m_wdata_q;

  assign req0_ready       = ready_v[0];
  assign req1_ready       = ready_v[1];
  assign req0_rdata       = m_rdata;
  assign req1_rdata       = m_rdata;
  assign req0_rdata_valid = m_rdata_valid && owner_v[0];
  assign req1_rdata_valid = m_rdata_valid && owner_v[1];
  assign req0_done        = (state_q == S_DONE) && !grant_q;
  assign req1_done        = (state_q == S_DONE) && grant_q;
  assign req0_ack_error   = req0_done && err_q;
  assign req1_ack_error   = req1_done && err_q;
  assign req0_timeout     = req0_done && timeout_q;
  assign req1_timeout     = req1_done && timeout_q;

endmodule

// File: tb/tb_iic_bus_arbiter.sv
// tb_iic_bus_arbiter -- self-checking bench for iic_bus_arbiter with a
// behavioural iic_drive model and an expected-completion scoreboard.
module tb_iic_bus_arbiter;

  localparam int DW     = 48;
  localparam int TMO    = 200;
  localparam int LOWMAX = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_start = 1'b0, req0_rw_flag = 1'b0;
  logic [3:0]    req0_byte_num = '0;
  logic [7:0]    req0_word_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_start = 1'b0, req1_rw_flag = 1'b0;
  logic [3:0]    req1_byte_num = '0;
  logic [7:0]    req1_word_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ready, req0_rdata_valid, req0_done, req0_ack_error, req0_timeout;
  logic          req1_ready, req1_rdata_valid, req1_done, req1_ack_error, req1_timeout;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic          m_start, m_ready, m_rw_flag, m_rdata_valid, m_ack_error;
  logic [3:0]    m_byte_num;
  logic [7:0]    m_word_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  always #5 clk = ~clk;

  iic_bus_arbiter #(
    .P_TIMEOUT_CYC  (TMO),
    .P_LOW_WAIT_MAX (LOWMAX),
    .P_DATA_W       (DW)
  ) dut (
    .clk (clk), .rst (rst),
    .req0_start (req0_start), .req0_rw_flag (req0_rw_flag), .req0_byte_num (req0_byte_num),
    .req0_word_addr (req0_word_addr), .req0_wdata (req0_wdata), .req0_ready (req0_ready),
    .req0_rdata (req0_rdata), .req0_rdata_valid (req0_rdata_valid), .req0_done (req0_done),
    .req0_ack_error (req0_ack_error), .req0_timeout (req0_timeout),
    .req1_start (req1_start), .req1_rw_flag (req1_rw_flag), .req1_byte_num (req1_byte_num),
    .req1_word_addr (req1_word_addr), .req1_wdata (req1_wdata), .req1_ready (req1_ready),
    .req1_rdata (req1_rdata), .req1_rdata_valid (req1_rdata_valid), .req1_done (req1_done),
    .req1_ack_error (req1_ack_error), .req1_timeout (req1_timeout),
    .m_start (m_start), .m_ready (m_ready), .m_rw_flag (m_rw_flag), .m_byte_num (m_byte_num),
    .m_word_addr (m_word_addr), .m_wdata (m_wdata), .m_rdata (m_rdata),
    .m_rdata_valid (m_rdata_valid), .m_ack_error (m_ack_error)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- iic_drive model ----------------
  int            cfg_drop = 2, cfg_busy = 100;
  bit            cfg_ack = 0, cfg_rd = 0, cfg_hang = 0, cfg_ignore = 0;
  logic [DW-1:0] cfg_rdata = '0;
  int            mphase, mcnt;

  always @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b1; m_rdata <= '0; m_rdata_valid <= 1'b0; m_ack_error <= 1'b0;
      mphase <= 0; mcnt <= 0;
    end else begin
      m_rdata_valid <= 1'b0;
      m_ack_error   <= 1'b0;
      case (mphase)
        0: if (m_start && !cfg_ignore) begin mphase <= 1; mcnt <= 1; end
        1: if (mcnt >= cfg_drop) begin m_ready <= 1'b0; mphase <= 2; mcnt <= 0; end
           else mcnt <= mcnt + 1;
        default: begin
          mcnt <= mcnt + 1;
          if (mcnt == cfg_busy / 2) begin
            m_ack_error <= cfg_ack;
            if (cfg_rd) begin m_rdata <= cfg_rdata; m_rdata_valid <= 1'b1; end
          end
          if (!cfg_hang && mcnt >= cfg_busy - 1) begin m_ready <= 1'b1; mphase <= 0; end
        end
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  // lat == 0: done expected one cycle after m_ready rises;
  // lat  > 0: done expected exactly lat cycles after m_start.
  typedef struct {
    int id; logic rw; logic [3:0] bn; logic [7:0] addr;
    logic [DW-1:0] wdata; logic [DW-1:0] rdata; logic err; logic tmo; int lat;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int   cyc = 0, rise_cyc = 0, start_cyc = 0, nstart = 0;
  logic ready_prev = 1'b1;
  logic [1:0] rv_exp;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      nstart     = 0;
      ready_prev = 1'b1;
    end else begin
      if (m_ready && !ready_prev) rise_cyc = cyc;
      ready_prev = m_ready;
      if (m_start) begin
        nstart++;
        start_cyc = cyc;
        check("start_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("m_rw_flag", m_rw_flag, exp_q[0].rw);
          check("m_byte_num", m_byte_num, exp_q[0].bn);
          check("m_word_addr", m_word_addr, exp_q[0].addr);
          check("m_wdata", m_wdata, exp_q[0].wdata);
        end
      end
      if (m_rdata_valid) begin
        rv_exp = 2'b00;
        if (exp_q.size() != 0) rv_exp = (exp_q[0].id == 1) ? 2'b10 : 2'b01;
        check("rdata_valid_route", {req1_rdata_valid, req0_rdata_valid}, rv_exp);
        if (exp_q.size() != 0)
          check("rdata", (exp_q[0].id == 1) ? req1_rdata : req0_rdata, exp_q[0].rdata);
      end else begin
        check("rdata_valid_idle", {req1_rdata_valid, req0_rdata_valid}, 2'b00);
      end
      if (req0_done || req1_done) begin
        check("done_onehot", req0_done && req1_done, 0);
        check("done_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("[TB] txn client=%0d addr=0x%02h ack_error=%0d timeout=%0d",
                   req1_done, m_word_addr, req1_done ? req1_ack_error : req0_ack_error,
                   req1_done ? req1_timeout : req0_timeout);
          check("done_id", req1_done, e.id);
          check("ack_error", req1_done ? req1_ack_error : req0_ack_error, e.err);
          check("timeout", req1_done ? req1_timeout : req0_timeout, e.tmo);
          check("fields_held", m_word_addr, e.addr);
          check("start_count", nstart, 1);
          if (e.lat == 0) check("done_latency", cyc - rise_cyc, 1);
          else            check("abort_latency", cyc - start_cyc, e.lat);
        end
        nstart = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input int id, input logic rw, input logic [3:0] bn, input logic [7:0] addr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                      input logic err, input logic tmo, input int lat);
    exp_t x;
    x.id = id; x.rw = rw; x.bn = bn; x.addr = addr; x.wdata = wd;
    x.rdata = rd; x.err = err; x.tmo = tmo; x.lat = lat;
    exp_q.push_back(x);
  endtask

  task automatic drive(input int id, input logic rw, input logic [3:0] bn,
                       input logic [7:0] addr, input logic [DW-1:0] wd);
    if (id == 0) begin
      req0_start = 1'b1; req0_rw_flag = rw; req0_byte_num = bn; req0_word_addr = addr; req0_wdata = wd;
    end else begin
      req1_start = 1'b1; req1_rw_flag = rw; req1_byte_num = bn; req1_word_addr = addr; req1_wdata = wd;
    end
  endtask

  task automatic pulse();
    @(posedge clk);
    #1;
    req0_start = 1'b0;
    req1_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ready(input int id, input int bound);
    for (int i = 0; i < bound && !(id == 0 ? req0_ready : req1_ready); i++) @(negedge clk);
    check("ready_in_time", id == 0 ? req0_ready : req1_ready, 1);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
    check("drained_in_time", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_busy(input int bound);
    for (int i = 0; i < bound && m_ready; i++) @(negedge clk);
    check("master_went_busy", m_ready, 0);
  endtask

  typedef struct {
    int id; logic rw; logic [3:0] bn; logic [7:0] addr; logic [DW-1:0] wdata;
    logic [DW-1:0] rdata; logic ack; int busy; logic err;
  } vec_t;
  vec_t vecs[5];
  vec_t v;

  initial begin
    vecs[0] = '{id:0, rw:1'b0, bn:4'd1, addr:8'h09, wdata:48'h40_00_00_00_00_00,
                rdata:48'h0, ack:1'b0, busy:100, err:1'b0};
    vecs[1] = '{id:1, rw:1'b1, bn:4'd6, addr:8'h07, wdata:48'h0,
                rdata:48'h0123_4567_89AB, ack:1'b0, busy:30, err:1'b0};
    vecs[2] = '{id:0, rw:1'b0, bn:4'd2, addr:8'h0A, wdata:48'hBE_EF_00_00_00_00,
                rdata:48'h0, ack:1'b1, busy:30, err:1'b1};
    vecs[3] = '{id:0, rw:1'b1, bn:4'd1, addr:8'h0B, wdata:48'h0,
                rdata:48'hA5_00_00_00_00_00, ack:1'b0, busy:30, err:1'b0};
    vecs[4] = '{id:1, rw:1'b0, bn:4'd3, addr:8'h20, wdata:48'h12_34_56_00_00_00,
                rdata:48'h0, ack:1'b1, busy:30, err:1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req0_ready", req0_ready, 1);
    check("rst_req1_ready", req1_ready, 1);
    check("rst_m_start", m_start, 0);
    check("rst_done", {req1_done, req0_done}, 0);
    check("rst_m_word_addr", m_word_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single transactions.
    foreach (vecs[i]) begin
      v = vecs[i];
      cfg_ack = v.ack; cfg_rd = v.rw; cfg_rdata = v.rdata; cfg_busy = v.busy;
      wait_ready(v.id, 50);
      push(v.id, v.rw, v.bn, v.addr, v.wdata, v.rdata, v.err, 1'b0, 0);
      drive(v.id, v.rw, v.bn, v.addr, v.wdata);
      pulse();
      wait_idle(400);
      repeat (2) @(negedge clk);
    end

    // Simultaneous starts right after reset, then round-robin alternation.
    cfg_ack = 0; cfg_rd = 0; cfg_busy = 20;
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    push(0, 1'b0, 4'd1, 8'h10, 48'h11_00_00_00_00_00, '0, 1'b0, 1'b0, 0);
    push(1, 1'b0, 4'd1, 8'h11, 48'h22_00_00_00_00_00, '0, 1'b0, 1'b0, 0);
    drive(0, 1'b0, 4'd1, 8'h10, 48'h11_00_00_00_00_00);
    drive(1, 1'b0, 4'd1, 8'h11, 48'h22_00_00_00_00_00);
    pulse();
    wait_idle(300);
    push(0, 1'b0, 4'd1, 8'h12, 48'h33_00_00_00_00_00, '0, 1'b0, 1'b0, 0);
    push(1, 1'b0, 4'd1, 8'h13, 48'h44_00_00_00_00_00, '0, 1'b0, 1'b0, 0);
    drive(0, 1'b0, 4'd1, 8'h12, 48'h33_00_00_00_00_00);
    drive(1, 1'b0, 4'd1, 8'h13, 48'h44_00_00_00_00_00);
    pulse();
    wait_idle(300);
    // After req0 alone, a simultaneous pair must go to req1 first.
    push(0, 1'b0, 4'd1, 8'h14, 48'h55_00_00_00_00_00, '0, 1'b0, 1'b0, 0);
    drive(0, 1'b0, 4'd1, 8'h14, 48'h55_00_00_00_00_00);
    pulse();
    wait_idle(300);
    push(1, 1'b0, 4'd1, 8'h15, 48'h66_00_00_00_00_00, '0, 1'b0, 1'b0, 0);
    push(0, 1'b0, 4'd1, 8'h16, 48'h77_00_00_00_00_00, '0, 1'b0, 1'b0, 0);
    drive(0, 1'b0, 4'd1, 8'h16, 48'h77_00_00_00_00_00);
    drive(1, 1'b0, 4'd1, 8'h15, 48'h66_00_00_00_00_00);
    pulse();
    wait_idle(300);

    // Master hangs busy: watchdog abort, then the queued req1 is served.
    cfg_hang = 1;
    push(0, 1'b0, 4'd1, 8'h30, 48'h01_00_00_00_00_00, '0, 1'b0, 1'b1, TMO);
    drive(0, 1'b0, 4'd1, 8'h30, 48'h01_00_00_00_00_00);
    pulse();
    push(1, 1'b0, 4'd1, 8'h31, 48'h02_00_00_00_00_00, '0, 1'b0, 1'b0, 0);
    wait_ready(1, 10);
    drive(1, 1'b0, 4'd1, 8'h31, 48'h02_00_00_00_00_00);
    pulse();
    for (int i = 0; i < 400 && exp_q.size() > 1; i++) @(negedge clk);
    check("hang_aborted", exp_q.size(), 1);
    cfg_hang = 0;
    wait_idle(300);

    // Master ignores m_start: lost-start abort.
    cfg_ignore = 1;
    push(1, 1'b1, 4'd2, 8'h40, 48'h0, '0, 1'b0, 1'b1, LOWMAX);
    drive(1, 1'b1, 4'd2, 8'h40, 48'h0);
    pulse();
    wait_idle(100);
    cfg_ignore = 0;
    repeat (2) @(negedge clk);

    // Start while not ready is ignored.
    cfg_busy = 40;
    push(0, 1'b0, 4'd1, 8'h50, 48'hAA_00_00_00_00_00, '0, 1'b0, 1'b0, 0);
    drive(0, 1'b0, 4'd1, 8'h50, 48'hAA_00_00_00_00_00);
    pulse();
    wait_busy(50);
    check("busy_req0_ready", req0_ready, 0);
    drive(0, 1'b0, 4'd1, 8'h55, 48'hBB_00_00_00_00_00);
    pulse();
    wait_idle(200);
    repeat (20) @(negedge clk);
    check("ignored_no_start", nstart, 0);
    check("ready_after_done", req0_ready, 1);

    // Reset while waiting for completion with req1 pending.
    cfg_busy = 100;
    push(0, 1'b0, 4'd1, 8'h60, 48'hCC_00_00_00_00_00, '0, 1'b0, 1'b0, 0);
    drive(0, 1'b0, 4'd1, 8'h60, 48'hCC_00_00_00_00_00);
    pulse();
    wait_busy(50);
    repeat (5) @(negedge clk);
    wait_ready(1, 5);
    drive(1, 1'b0, 4'd1, 8'h61, 48'hDD_00_00_00_00_00);
    pulse();
    check("pending_req1_ready", req1_ready, 0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_m_start", m_start, 0);
    check("midrst_req0_ready", req0_ready, 1);
    check("midrst_req1_ready", req1_ready, 1);
    check("midrst_done", {req1_done, req0_done}, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("post_rst_no_start", nstart, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
